// File: rtl/mmio_bridge.sv
// mmio_bridge: routes miniRV MEM-stage accesses to data RAM or LED/SW/7-seg/timer registers; timer built only with `define TIMER_EN.
// Latency: reads combinational (same cycle), writes commit on the rising clk edge.
// Backpressure: none, every access completes in the cycle it is presented.
module mmio_bridge #(
   parameter int DRAM_AW     = 14,
   parameter int SCAN_CYCLES = 50000,
   parameter int TIMER_DIV   = 100
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        addr_from_cpu,
   input  logic               we_from_cpu,
   input  logic [31:0]        wdata_from_cpu,
   output logic [31:0]        rdata_to_cpu,
   output logic [DRAM_AW-1:0] dram_adr,
   output logic               dram_we,
   output logic [31:0]        dram_wdin,
   input  logic [31:0]        dram_rd,
   input  logic [23:0]        sw,
   output logic [23:0]        led,
   output logic [7:0]         an,
   output logic [7:0]         seg
);

   localparam logic [11:0] OFF_SEG   = 12'h000;
   localparam logic [11:0] OFF_TIMER = 12'h020;
   localparam logic [11:0] OFF_LED   = 12'h060;
   localparam logic [11:0] OFF_SW    = 12'h070;
   localparam int          SCW       = $clog2(SCAN_CYCLES);

   logic        periph;
   logic [11:0] off;
   logic        wr_seg;
   logic        wr_led;
   logic [31:0] seg_reg;
   logic [31:0] timer_val;
   logic [23:0] sw_meta;
   logic [23:0] sw_sync;
   logic [SCW-1:0] scan_cnt;
   logic [2:0]  idx;
   logic [3:0]  nib;

   assign periph = (addr_from_cpu[31:12] == 20'hFFFFF);
   assign off    = addr_from_cpu[11:0];
   assign wr_seg = we_from_cpu & periph & (off == OFF_SEG);
   assign wr_led = we_from_cpu & periph & (off == OFF_LED);

   assign dram_we   = we_from_cpu & ~periph;
   assign dram_wdin = wdata_from_cpu;
   assign dram_adr  = addr_from_cpu[DRAM_AW+1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led     <= '0;
         seg_reg <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         if (wr_led) led <= wdata_from_cpu[23:0];
         if (wr_seg) seg_reg <= wdata_from_cpu;
         sw_meta <= sw;
         sw_sync <= sw_meta;
      end
   end

`ifdef TIMER_EN
   localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

   logic          wr_timer;
   logic [PW-1:0] pre;
   logic          pre_wrap;

   assign wr_timer = we_from_cpu & periph & (off == OFF_TIMER);
   assign pre_wrap = (pre == PW'(TIMER_DIV - 1));

   // A CPU write restarts the prescaler and wins over a same-cycle tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre       <= '0;
         timer_val <= '0;
      end else if (wr_timer) begin
         pre       <= '0;
         timer_val <= wdata_from_cpu;
      end else if (pre_wrap) begin
         pre       <= '0;
         timer_val <= timer_val + 32'd1;
      end else begin
         pre <= pre + 1'b1;
      end
   end
`else
   assign timer_val = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == SCW'(SCAN_CYCLES - 1)) begin
         scan_cnt <= '0;
         idx      <= idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Display path is combinational from seg_reg so writes show up without restarting the scan.
   assign an  = ~(8'b1 << idx);
   assign nib = seg_reg[{idx, 2'b00} +: 4];

   always_comb begin
      seg = 8'hFF;
      case (nib)
         4'h0: seg = 8'hC0;
         4'h1: seg = 8'hF9;
         4'h2: seg = 8'hA4;
         4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h92;
         4'h6: seg = 8'h82;
         4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h88;
         4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;
         4'hD: seg = 8'hA1;
         4'hE: seg = 8'h86;
         default: seg = 8'h8E;
      endcase
   end

   always_comb begin
      rdata_to_cpu = dram_rd;
      if (periph) begin
         case (off)
            OFF_SEG:   rdata_to_cpu = seg_reg;
            OFF_TIMER: rdata_to_cpu = timer_val;
            OFF_LED:   rdata_to_cpu = {8'h0, led};
            OFF_SW:    rdata_to_cpu = {8'h0, sw_sync};
            default:   rdata_to_cpu = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed scenarios plus randomized traffic against a cycle-count based model.
module tb_mmio_bridge;

   localparam int          AW  = 14;
   localparam int          SC  = 4;
   localparam int          TD  = 3;
   localparam int unsigned SCU = 4;
   localparam int unsigned TDU = 3;
`ifdef TIMER_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif
   localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   addr_from_cpu = '0;
   logic          we_from_cpu = 1'b0;
   logic [31:0]   wdata_from_cpu = '0;
   logic [31:0]   rdata_to_cpu;
   logic [AW-1:0] dram_adr;
   logic          dram_we;
   logic [31:0]   dram_wdin;
   logic [31:0]   dram_rd = '0;
   logic [23:0]   sw = '0;
   logic [23:0]   led;
   logic [7:0]    an;
   logic [7:0]    seg;

   int errors = 0;
   int checks = 0;

   // Model state: edges since reset release, register images, last timer write.
   int unsigned edges;
   logic [31:0] m_led = '0;
   logic [31:0] m_seg = '0;
   logic [31:0] m_tw  = '0;
   int unsigned m_tc  = 0;

   mmio_bridge #(.DRAM_AW(AW), .SCAN_CYCLES(SC), .TIMER_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n), .addr_from_cpu(addr_from_cpu), .we_from_cpu(we_from_cpu),
      .wdata_from_cpu(wdata_from_cpu), .rdata_to_cpu(rdata_to_cpu), .dram_adr(dram_adr),
      .dram_we(dram_we), .dram_wdin(dram_wdin), .dram_rd(dram_rd), .sw(sw), .led(led),
      .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   function automatic logic [31:0] exp_timer(input int unsigned e);
      if (!TEN) return 32'h0;
      return m_tw + 32'((e - m_tc) / TDU);
   endfunction

   function automatic logic [7:0] exp_an(input int unsigned e);
      int unsigned d;
      d = (e / SCU) % 8;
      return ~(8'h1 << d);
   endfunction

   function automatic logic [7:0] exp_seg(input int unsigned e);
      int unsigned d;
      logic [31:0] t;
      d = (e / SCU) % 8;
      t = m_seg >> (4 * d);
      return HEX[t[3:0]];
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a, input int unsigned e);
      if (a[31:12] != 20'hFFFFF) return dram_rd;
      case (a[11:0])
         12'h000: return m_seg;
         12'h020: return exp_timer(e);
         12'h060: return m_led;
         12'h070: return {8'h0, sw};
         default: return 32'h0;
      endcase
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v, output int unsigned e);
      addr_from_cpu = a;
      we_from_cpu   = 1'b0;
      #1;
      v = rdata_to_cpu;
      e = edges;
      step(1);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr_from_cpu  = a;
      wdata_from_cpu = d;
      we_from_cpu    = 1'b1;
      step(1);
      we_from_cpu = 1'b0;
      if (a[31:12] == 20'hFFFFF) begin
         case (a[11:0])
            12'h000: m_seg = d;
            12'h020: begin m_tw = d; m_tc = edges; end
            12'h060: m_led = {8'h0, d[23:0]};
            default: ;
         endcase
      end
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      m_led = '0; m_seg = '0; m_tw = '0; m_tc = 0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      int unsigned e;
      #12;
      checks++; if (led !== 24'h0) begin errors++; $display("FAIL rst_led_held: got %h expected 000000", led); end
      checks++; if (an !== 8'hFE) begin errors++; $display("FAIL rst_an_held: got %h expected fe", an); end
      checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL rst_seg_held: got %h expected c0", seg); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++; if (an !== 8'hFE) begin errors++; $display("FAIL rst_an: got %h expected fe", an); end
      rd(32'hFFFFF020, v, e);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_timer: got %h expected 0", v); end
      rd(32'hFFFFF000, v, e);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_seg_reg: got %h expected 0", v); end
   endtask

   task automatic test_dram();
      logic [31:0] v, a;
      int unsigned e;
      addr_from_cpu = 32'h10; wdata_from_cpu = 32'h12345678; we_from_cpu = 1'b1;
      #1;
      checks++; if (dram_we !== 1'b1) begin errors++; $display("FAIL dram_we: got %b expected 1", dram_we); end
      checks++; if (dram_adr !== 14'd4) begin errors++; $display("FAIL dram_adr: got %h expected 4", dram_adr); end
      checks++; if (dram_wdin !== 32'h12345678) begin errors++; $display("FAIL dram_wdin: got %h expected 12345678", dram_wdin); end
      addr_from_cpu = 32'hFFFFF060;
      #1;
      checks++; if (dram_we !== 1'b0) begin errors++; $display("FAIL dram_we_periph: got %b expected 0", dram_we); end
      we_from_cpu = 1'b0;
      step(1);
      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
         dram_rd = $urandom;
         addr_from_cpu = a;
         #1;
         checks++; if (dram_adr !== a[AW+1:2]) begin errors++; $display("FAIL dram_adr_rand: got %h expected %h", dram_adr, a[AW+1:2]); end
         rd(a, v, e);
         checks++; if (v !== dram_rd) begin errors++; $display("FAIL dram_read: got %h expected %h", v, dram_rd); end
      end
   endtask

   task automatic test_led_sw();
      logic [31:0] v;
      int unsigned e;
      logic [23:0] old_sw;
      wr(32'hFFFFF060, 32'h00ABCDEF);
      checks++; if (led !== 24'hABCDEF) begin errors++; $display("FAIL led_out: got %h expected abcdef", led); end
      rd(32'hFFFFF060, v, e);
      checks++; if (v !== 32'h00ABCDEF) begin errors++; $display("FAIL led_read: got %h expected 00abcdef", v); end
      for (int i = 0; i < 4; i++) begin
         old_sw = sw;
         sw = (i == 0) ? 24'h00F00F : 24'($urandom);
         rd(32'hFFFFF070, v, e);
         checks++; if (v !== {8'h0, old_sw}) begin errors++; $display("FAIL sw_edge0: got %h expected %h", v, {8'h0, old_sw}); end
         rd(32'hFFFFF070, v, e);
         checks++; if (v !== {8'h0, old_sw}) begin errors++; $display("FAIL sw_edge1: got %h expected %h", v, {8'h0, old_sw}); end
         rd(32'hFFFFF070, v, e);
         checks++; if (v !== {8'h0, sw}) begin errors++; $display("FAIL sw_edge2: got %h expected %h", v, {8'h0, sw}); end
      end
   endtask

   task automatic test_display();
      reset_dut();
      wr(32'hFFFFF000, 32'h0000001F);
      checks++; if (an !== 8'hFE || seg !== 8'h8E) begin errors++; $display("FAIL disp_idx0: got an=%h seg=%h expected an=fe seg=8e", an, seg); end
      while (edges < 5) step(1);
      checks++; if (an !== 8'hFD || seg !== 8'hF9) begin errors++; $display("FAIL disp_idx1: got an=%h seg=%h expected an=fd seg=f9", an, seg); end
      while (edges < 33) step(1);
      checks++; if (an !== 8'hFE || seg !== 8'h8E) begin errors++; $display("FAIL disp_wrap: got an=%h seg=%h expected an=fe seg=8e", an, seg); end
      for (int i = 0; i < 48; i++) begin
         if ($urandom_range(0, 3) == 0) wr(32'hFFFFF000, $urandom);
         else step(1);
         checks++;
         if (an !== exp_an(edges) || seg !== exp_seg(edges)) begin
            errors++;
            $display("FAIL disp_scan: got an=%h seg=%h expected an=%h seg=%h", an, seg, exp_an(edges), exp_seg(edges));
         end
      end
   endtask

   task automatic test_timer();
      logic [31:0] v;
      int unsigned e, cw;
      reset_dut();
      wr(32'hFFFFF020, 32'hFFFFFFFE);
      cw = edges;
      while (edges < cw + 2) step(1);
      rd(32'hFFFFF020, v, e);
      checks++; if (v !== (TEN ? 32'hFFFFFFFE : 32'h0)) begin errors++; $display("FAIL timer_hold: got %h expected %h", v, TEN ? 32'hFFFFFFFE : 32'h0); end
      rd(32'hFFFFF020, v, e);
      checks++; if (v !== (TEN ? 32'hFFFFFFFF : 32'h0)) begin errors++; $display("FAIL timer_inc: got %h expected %h", v, TEN ? 32'hFFFFFFFF : 32'h0); end
      while (edges < cw + 6) step(1);
      rd(32'hFFFFF020, v, e);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL timer_wrap: got %h expected 0", v); end
      while (edges < cw + 8) step(1);
      wr(32'hFFFFF020, 32'h5);
      rd(32'hFFFFF020, v, e);
      checks++; if (v !== (TEN ? 32'h5 : 32'h0)) begin errors++; $display("FAIL timer_write_wins: got %h expected %h", v, TEN ? 32'h5 : 32'h0); end
      while (edges < cw + 12) step(1);
      rd(32'hFFFFF020, v, e);
      checks++; if (v !== (TEN ? 32'h6 : 32'h0)) begin errors++; $display("FAIL timer_after_write: got %h expected %h", v, TEN ? 32'h6 : 32'h0); end
      for (int i = 0; i < 10; i++) begin
         wr(32'hFFFFF020, $urandom);
         step($urandom_range(0, 10));
         rd(32'hFFFFF020, v, e);
         checks++; if (v !== exp_timer(e)) begin errors++; $display("FAIL timer_rand: got %h expected %h", v, exp_timer(e)); end
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] v, a;
      int unsigned e;
      wr(32'hFFFFF060, 32'h00123456);
      for (int i = 0; i < 6; i++) begin
         a = {20'hFFFFF, 12'($urandom)};
         if (i == 0) a = 32'hFFFFF100;
         if (a[11:0] == 12'h000 || a[11:0] == 12'h020 || a[11:0] == 12'h060 || a[11:0] == 12'h070) a[11:0] = 12'h004;
         addr_from_cpu = a; wdata_from_cpu = 32'hDEADBEEF; we_from_cpu = 1'b1;
         #1;
         checks++; if (dram_we !== 1'b0) begin errors++; $display("FAIL unmapped_dram_we: got %b expected 0", dram_we); end
         wr(a, 32'hDEADBEEF);
         checks++; if (led !== m_led[23:0]) begin errors++; $display("FAIL unmapped_led: got %h expected %h", led, m_led[23:0]); end
         rd(32'hFFFFF000, v, e);
         checks++; if (v !== m_seg) begin errors++; $display("FAIL unmapped_seg: got %h expected %h", v, m_seg); end
         rd(32'hFFFFF020, v, e);
         checks++; if (v !== exp_timer(e)) begin errors++; $display("FAIL unmapped_timer: got %h expected %h", v, exp_timer(e)); end
         rd(a, v, e);
         checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", v); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d, v, x;
      int unsigned e;
      for (int i = 0; i < 200; i++) begin
         d = $urandom;
         case ($urandom_range(0, 5))
            0: a = 32'hFFFFF000;
            1: a = 32'hFFFFF020;
            2: a = 32'hFFFFF060;
            3: a = 32'hFFFFF070;
            4: begin a = $urandom; if (a[31:12] == 20'hFFFFF) a[30] = 1'b0; end
            default: begin
               a = {20'hFFFFF, 12'($urandom)};
               if (a[11:0] == 12'h000 || a[11:0] == 12'h020 || a[11:0] == 12'h060 || a[11:0] == 12'h070) a[11:0] = 12'h7FC;
            end
         endcase
         if ($urandom_range(0, 1) == 1) begin
            addr_from_cpu = a; wdata_from_cpu = d; we_from_cpu = 1'b1;
            #1;
            checks++; if (dram_we !== (a[31:12] != 20'hFFFFF)) begin errors++; $display("FAIL rand_dram_we: got %b for addr %h", dram_we, a); end
            wr(a, d);
         end else begin
            dram_rd = $urandom;
            rd(a, v, e);
            x = exp_read(a, e);
            checks++; if (v !== x) begin errors++; $display("FAIL rand_read: addr %h got %h expected %h", a, v, x); end
         end
      end
      checks++; if (led !== m_led[23:0]) begin errors++; $display("FAIL rand_led: got %h expected %h", led, m_led[23:0]); end
   endtask

   task automatic test_async_reset();
      wr(32'hFFFFF060, 32'h005A5A5A);
      wr(32'hFFFFF000, 32'h89ABCDEF);
      wr(32'hFFFFF020, 32'h00001234);
      step(6);
      rst_n = 1'b0;
      addr_from_cpu = 32'hFFFFF000;
      #1;
      checks++; if (led !== 24'h0) begin errors++; $display("FAIL arst_led: got %h expected 000000", led); end
      checks++; if (an !== 8'hFE || seg !== 8'hC0) begin errors++; $display("FAIL arst_disp: got an=%h seg=%h expected an=fe seg=c0", an, seg); end
      checks++; if (rdata_to_cpu !== 32'h0) begin errors++; $display("FAIL arst_seg_reg: got %h expected 0", rdata_to_cpu); end
      addr_from_cpu = 32'hFFFFF020;
      #1;
      checks++; if (rdata_to_cpu !== 32'h0) begin errors++; $display("FAIL arst_timer: got %h expected 0", rdata_to_cpu); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_led = '0; m_seg = '0; m_tw = '0; m_tc = 0;
   endtask

   initial begin
      test_reset();
      test_dram();
      test_led_sw();
      test_display();
      test_timer();
      test_unmapped();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Responder for the miniRV core's data-memory port: decodes the byte address the core drives in MEM and routes each access to data RAM or a memory-mapped peripheral.
- Peripherals: LED register, switch input, 8-digit seven-segment display with scanner, and a prescaled 32-bit timer.
- Read path is combinational so the core receives read data in the same cycle. Writes commit on the rising clk edge.

Parameters:
- DRAM_AW, 14, DRAM word-address width; dram_adr = addr_from_cpu[DRAM_AW+1:2].
- SCAN_CYCLES, 50000, clk cycles each display digit stays lit (>=2).
- TIMER_DIV, 100, clk cycles per timer increment (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr_from_cpu  in  32  byte address from core MEM stage
- we_from_cpu  in  1  store strobe
- wdata_from_cpu  in  32  store data
- rdata_to_cpu  out  32  load data (combinational)
- dram_adr  out  DRAM_AW  word address to data RAM
- dram_we  out  1  RAM write enable
- dram_wdin  out  32  RAM write data
- dram_rd  in  32  RAM read data (combinational)
- sw  in  24  board switches (asynchronous)
- led  out  24  board LEDs, active-high
- an  out  8  digit enables, active-low
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Decode: peripheral space when addr_from_cpu[31:12]==20'hFFFFF; all other addresses are DRAM.
- Peripheral offsets, addr[11:0]:
  - 0x000 SEG: 32-bit, read/write.
  - 0x020 TIMER: 32-bit, read/write.
  - 0x060 LED: 24-bit, read/write.
  - 0x070 SW: read-only.
- Unmapped peripheral offsets read 32'h0; writes to them are ignored.
- dram_we = we_from_cpu & ~peripheral. dram_wdin = wdata_from_cpu always. dram_adr is always driven from the address bits.
- Read mux:
  - DRAM -> dram_rd
  - SEG -> seg_reg
  - TIMER -> timer_val
  - LED -> {8'h0, led}
  - SW -> {8'h0, sw_sync}
- Writes at the clk edge with we_from_cpu=1: SEG -> seg_reg <= wdata; LED -> led <= wdata[23:0].
- SW synchronizer: two flops. sw_sync reflects a sw change after 2 clk edges.
- Display scanner:
  - scan_cnt counts 0..SCAN_CYCLES-1. On terminal count it resets to 0 and digit index idx advances; idx wraps 7->0.
  - an = ~(8'b1 << idx).
  - seg = active-low hex decode of seg_reg[4*idx+3:4*idx], dp=1 (off).
  - Hex codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - A seg_reg write takes effect on the next cycle's seg output without disturbing the scan.
- Timer:
  - pre counts 0..TIMER_DIV-1. On wrap, timer_val <= timer_val+1, modulo 2^32 (FFFFFFFF->0).
  - TIMER write: timer_val <= wdata and pre <= 0. The write takes priority over an increment in the same cycle.
- Reset values: led=0, seg_reg=0, timer_val=0, pre=0, scan_cnt=0, idx=0, sw_sync=0, an=8'hFE, seg=8'hC0.
- Reset asserted mid-operation returns all of these immediately to their reset values, with no clock needed.
- rdata_to_cpu, dram_we, dram_adr and dram_wdin are purely combinational from inputs and registers; no reset value of their own.

Optional Feature:
- Macro TIMER_EN.
- Defined: timer present as described.
- Undefined: timer logic omitted; TIMER reads 32'h0 and writes are ignored; no timer flops are synthesized.

Test Plan:
- Reset: hold rst_n=0, then release -> led=0, an=FE, seg=C0. Read 0xFFFFF020 -> 0. Read 0xFFFFF000 -> 0.
- DRAM: store 0x12345678 to 0x00000010 -> dram_we=1 and dram_adr=4. Store the same data to 0xFFFFF060 -> dram_we=0.
- LED/SW: write 0x00ABCDEF to 0xFFFFF060 -> led=ABCDEF next cycle, readback 0x00ABCDEF. Set sw=0x00F00F -> read 0xFFFFF070 returns 0x0000F00F after 2 edges, old value before.
- Display: SCAN_CYCLES=4, write 0x0000001F to SEG -> idx0 an=FE seg=8E; after 4 cycles an=FD seg=F9; after 32 cycles back to an=FE.
- Timer: TIMER_DIV=3, write FFFFFFFE -> after 3 cycles FFFFFFFF, after 6 cycles 0. A write of 0x5 on the wrap cycle -> 0x5 (write wins). Rebuilt without TIMER_EN -> reads 0.
- Unmapped: write 0xDEADBEEF to 0xFFFFF100 -> no register changes, dram_we=0, read returns 0.
